// File: rtl/multi_channel_phase_timer_pkg.sv
// ---------------------------------------------------------------------------
// phase_timer_pkg
// Shared constants and helpers for the multi-channel phase timer.
//   DEF_NUM_CH / DEF_WIDTH / DEF_PRESCALE : default parameter values
//   ch_lsb()          : lowest bit of channel ch inside a packed NUM_CH*WIDTH bus
//   prescale_width()  : width of the shared prescale counter (at least 1 bit)
// ---------------------------------------------------------------------------
package phase_timer_pkg;

    localparam int unsigned DEF_NUM_CH   = 4;
    localparam int unsigned DEF_WIDTH    = 7;
    localparam int unsigned DEF_PRESCALE = 10;

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

    function automatic int unsigned prescale_width(input int unsigned prescale);
        return (prescale > 2) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/multi_channel_phase_timer_channel.sv
// ---------------------------------------------------------------------------
// phase_timer_channel
// One countdown channel: count register, reload register, expire register and
// the priority mux between them (rst > load > decrement > reload > hold).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   ld           : load strobe (per-channel load already ORed with emg_load)
//   down         : count enable
//   auto_reload  : 1 = reload from reload register at zero, 0 = saturate at zero
//   tick         : count tick from the shared prescaler (constant 1 without it)
//   load_val     : value written to both count and reload registers on ld
//   count        : current count
//   is_zero      : combinational count == 0
//   expire       : registered one-cycle pulse on the 1 -> 0 step
// ---------------------------------------------------------------------------
module phase_timer_channel
    import phase_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             down,
    input  logic             auto_reload,
    input  logic             tick,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             is_zero,
    output logic             expire
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (ld) begin
            // A load always wins, which also swallows a coincident 1 -> 0 expire.
            count_d  = load_val;
            reload_d = load_val;
        end else if (down && tick) begin
            if (count_q != '0) begin
                count_d  = count_q - 1'b1;
                expire_d = (count_q == WIDTH'(1));
            end else if (auto_reload) begin
                // Reload only after one visible tick at zero: period is N+1 ticks.
                count_d = reload_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    assign count   = count_q;
    assign is_zero = (count_q == '0);
    assign expire  = expire_q;

endmodule

// File: rtl/multi_channel_phase_timer.sv
// ---------------------------------------------------------------------------
// multi_channel_phase_timer
// NUM_CH independent countdown timers for the traffic-light phase FSM.
// Optional shared tick prescaler, compiled in with PHASE_TIMER_PRESCALE_EN;
// without it every clk cycle is a count tick and PRESCALE is only range-checked.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   emg_load     : global emergency load, ORed into every channel's load
//   load         : per-channel load strobe
//   down         : per-channel count enable
//   auto_reload  : per-channel mode (1 = auto-reload, 0 = one-shot)
//   load_val     : packed load values, channel i at [i*WIDTH +: WIDTH]
//   curr_count   : packed current counts, same packing
//   is_zero      : per-channel count == 0 (combinational)
//   expire       : per-channel registered 1 -> 0 pulse
// ---------------------------------------------------------------------------
module multi_channel_phase_timer
    import phase_timer_pkg::*;
#(
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    emg_load,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH-1:0]       down,
    input  logic [NUM_CH-1:0]       auto_reload,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    output logic [NUM_CH*WIDTH-1:0] curr_count,
    output logic [NUM_CH-1:0]       is_zero,
    output logic [NUM_CH-1:0]       expire
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("NUM_CH must be >= 1");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("WIDTH must be >= 2");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("PRESCALE must be >= 2");
    end

    logic tick;

`ifdef PHASE_TIMER_PRESCALE_EN
    localparam int unsigned     PS_W    = prescale_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    // Free-running: loads never realign the prescaler.
    always_comb begin
        ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign tick = (ps_q == PS_LAST);
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int unsigned LSB = ch_lsb(i, WIDTH);

        phase_timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .ld          (load[i] | emg_load),
            .down        (down[i]),
            .auto_reload (auto_reload[i]),
            .tick        (tick),
            .load_val    (load_val[LSB +: WIDTH]),
            .count       (curr_count[LSB +: WIDTH]),
            .is_zero     (is_zero[i]),
            .expire      (expire[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_phase_timer.sv
module tb_multi_channel_phase_timer;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    emg_load;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH-1:0]       down;
    logic [NUM_CH-1:0]       auto_reload;
    logic [NUM_CH*WIDTH-1:0] load_val;
    logic [NUM_CH*WIDTH-1:0] curr_count;
    logic [NUM_CH-1:0]       is_zero;
    logic [NUM_CH-1:0]       expire;

    multi_channel_phase_timer #(
        .NUM_CH   (NUM_CH),
        .WIDTH    (WIDTH),
        .PRESCALE (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .emg_load    (emg_load),
        .load        (load),
        .down        (down),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .curr_count  (curr_count),
        .is_zero     (is_zero),
        .expire      (expire)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH*WIDTH-1:0] cnt;
        logic [NUM_CH-1:0]       z;
        logic [NUM_CH-1:0]       ex;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Monitor: one expected entry is pushed after every stimulus edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if (curr_count !== e.cnt || is_zero !== e.z || expire !== e.ex) begin
                miscompares++;
                $display("FAIL %s: got count=%h is_zero=%b expire=%b, want count=%h is_zero=%b expire=%b",
                         nm, curr_count, is_zero, expire, e.cnt, e.z, e.ex);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [3:0] ld,
                        input logic [3:0] dn, input logic [3:0] ar,
                        input logic [6:0] v3, input logic [6:0] v2,
                        input logic [6:0] v1, input logic [6:0] v0,
                        input logic [6:0] x3, input logic [6:0] x2,
                        input logic [6:0] x1, input logic [6:0] x0,
                        input logic [3:0] xexp, input string nm);
        exp_t ex;
        rst         = r;
        emg_load    = e;
        load        = ld;
        down        = dn;
        auto_reload = ar;
        load_val    = {v3, v2, v1, v0};
        @(posedge clk);
        #1;
        ex.cnt = {x3, x2, x1, x0};
        ex.z   = {x3 == 7'd0, x2 == 7'd0, x1 == 7'd0, x0 == 7'd0};
        ex.ex  = xexp;
        sb_q.push_back(ex);
        name_q.push_back(nm);
    endtask

    initial begin
        rst = 1'b1; emg_load = 1'b0; load = '0; down = '0; auto_reload = '0; load_val = '0;
        //    r  e  load     down     ar       v3 v2 v1 v0   x3 x2 x1 x0  expire
        step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0000, "reset_init");
        // ch1 one-shot from 3
        step(0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0, 3, 0,   0, 0, 3, 0, 4'b0000, "os_load");
        step(0, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0,   0, 0, 2, 0, 4'b0000, "os_2");
        step(0, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0000, "os_1");
        step(0, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0010, "os_expire");
        step(0, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0000, "os_sat");
        step(0, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0000, "os_sat2");
        // ch2 auto-reload from 2: period 3
        step(0, 0, 4'b0100, 4'b0000, 4'b0100, 0, 2, 0, 0,   0, 2, 0, 0, 4'b0000, "ar_load");
        step(0, 0, 4'b0000, 4'b0100, 4'b0100, 0, 0, 0, 0,   0, 1, 0, 0, 4'b0000, "ar_1");
        step(0, 0, 4'b0000, 4'b0100, 4'b0100, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0100, "ar_expire");
        step(0, 0, 4'b0000, 4'b0100, 4'b0100, 0, 0, 0, 0,   0, 2, 0, 0, 4'b0000, "ar_reload");
        step(0, 0, 4'b0000, 4'b0100, 4'b0100, 0, 0, 0, 0,   0, 1, 0, 0, 4'b0000, "ar_1b");
        step(0, 0, 4'b0000, 4'b0100, 4'b0100, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0100, "ar_expire2");
        step(0, 0, 4'b0000, 4'b0100, 4'b0100, 0, 0, 0, 0,   0, 2, 0, 0, 4'b0000, "ar_reload2");
        // ch0 load coinciding with 1 -> 0 step
        step(0, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 1,   0, 2, 0, 1, 4'b0000, "coin_load1");
        step(0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 7,   0, 2, 0, 7, 4'b0000, "coin_load7");
        // ch3 freeze with down 1,0,0,1
        step(0, 0, 4'b1000, 4'b0000, 4'b0000, 4, 0, 0, 0,   4, 2, 0, 7, 4'b0000, "frz_load");
        step(0, 0, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0, 0,   3, 2, 0, 7, 4'b0000, "frz_dn");
        step(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0,   3, 2, 0, 7, 4'b0000, "frz_hold1");
        step(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0,   3, 2, 0, 7, 4'b0000, "frz_hold2");
        step(0, 0, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0, 0,   2, 2, 0, 7, 4'b0000, "frz_dn2");
        // ch1 load 0 in auto-reload: stays 0, never expires
        step(0, 0, 4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 0,   2, 2, 0, 7, 4'b0000, "z_load");
        step(0, 0, 4'b0000, 4'b0010, 4'b0010, 0, 0, 0, 0,   2, 2, 0, 7, 4'b0000, "z_ar1");
        step(0, 0, 4'b0000, 4'b0010, 4'b0010, 0, 0, 0, 0,   2, 2, 0, 7, 4'b0000, "z_ar2");
        step(0, 0, 4'b0000, 4'b0010, 4'b0010, 0, 0, 0, 0,   2, 2, 0, 7, 4'b0000, "z_ar3");
        // emergency load of every channel
        step(0, 1, 4'b0000, 4'b0000, 4'b0000, 9, 8, 7, 6,   9, 8, 7, 6, 4'b0000, "emg_load");
        step(0, 0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0,   9, 8, 7, 5, 4'b0000, "emg_dn");
        // reset overrides load and down mid-countdown
        step(1, 1, 4'b0001, 4'b1111, 4'b1111, 1, 2, 3, 3,   0, 0, 0, 0, 4'b0000, "rst_mid");
        step(0, 0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0000, "post_rst");
        step(0, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0000, "post_rst_os");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries still pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_channel_phase_timer.md
Name: multi_channel_phase_timer

Overview:
- Parametrised successor to the single-channel saturating countdown timer used by the traffic-light controller.
- NUM_CH independent countdown channels, one per signal phase or approach. Each channel has a per-channel load, a count enable, a one-shot or auto-reload mode, a held reload value and a registered expiry pulse.
- Sits between the phase FSM, which issues load and count commands, and the light-output logic, which consumes the is_zero and expire flags.

Parameters:
- NUM_CH, 4, number of independent timer channels (>=1).
- WIDTH, 7, counter width per channel in bits (>=2).
- PRESCALE, 10, clk cycles per count tick; used only when the optional feature is compiled in (>=2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- emg_load  input  1  global emergency load; every channel loads its load_val slice this cycle.
- load  input  NUM_CH  per-channel load strobe.
- down  input  NUM_CH  per-channel count enable.
- auto_reload  input  NUM_CH  per-channel mode: 1 = reload from reload register at zero, 0 = saturate at zero.
- load_val  input  NUM_CH*WIDTH  packed load values; channel i occupies bits [i*WIDTH +: WIDTH].
- curr_count  output  NUM_CH*WIDTH  packed current counts, same packing as load_val.
- is_zero  output  NUM_CH  combinational: channel count equals 0.
- expire  output  NUM_CH  registered one-cycle pulse when a channel counts from 1 to 0.

Behaviour:
- Reset: clk rising edge with rst=1 clears every count and reload register to 0 and clears expire to 0. Consequently is_zero = all ones. rst overrides all other inputs, including mid-countdown.
- Per-channel priority each cycle, highest first:
  (1) rst.
  (2) ld = load[i] | emg_load: count <= load_val slice; reload register <= load_val slice; expire <= 0.
  (3) Decrement: down[i] & tick & count != 0: count <= count-1; expire <= (count == 1).
  (4) Reload: down[i] & tick & count == 0 & auto_reload[i]: count <= reload register; expire <= 0.
  (5) Otherwise hold count; expire <= 0.
- tick = 1 every cycle unless the optional feature is compiled in.
- Saturation: in one-shot mode count never wraps below 0; it holds 0 while down stays high.
- Auto-reload latency: exactly one tick at 0 is visible before the reloaded value appears, so a load of N gives a period of N+1 ticks.
- Load of 0: count = 0, is_zero = 1, expire never pulses. In auto-reload mode the channel reloads 0 forever with no expire.
- Load while counting: the load wins and the countdown restarts from the new value. A load coinciding with the 1->0 step suppresses expire.
- down low: count freezes. A pending tick is lost, not queued.
- Channels are fully independent. emg_load is a pure OR into each channel's load.
- Arithmetic: unsigned, WIDTH bits. load_val is used as-is, with no clamping.

Optional Feature:
- Macro PHASE_TIMER_PRESCALE_EN.
- Defined:
  - A shared prescale counter of width clog2(PRESCALE) is added, reset to 0 by rst.
  - It increments every cycle and wraps from PRESCALE-1 to 0.
  - tick = (prescale counter == PRESCALE-1).
  - Loads and emg_load do not reset the prescaler, and loads take effect immediately regardless of tick.
- Undefined: no prescaler logic exists, tick = 1 constantly, and PRESCALE is ignored.

Decomposition:
- Package phase_timer_pkg holds:
  - the default WIDTH and NUM_CH constants;
  - a channel-index-to-slice helper function;
  - the clog2-based prescale width function.
- Sub-module phase_timer_channel implements one channel: count register, reload register, expire register and priority mux.
- It is instantiated NUM_CH times in a generate loop. The top level holds only the prescaler and the port packing.

Test Plan:
- Reset: assert rst mid-countdown with ch0 at 5 -> next cycle all curr_count = 0, is_zero = 4'b1111, expire = 0.
- One-shot: ch1 load 3, down = 1, auto_reload = 0 -> counts 3, 2, 1, 0, 0, ...; expire[1] high only in the first cycle count = 0; is_zero[1] stays 1.
- Auto-reload: ch2 load 2, auto_reload = 1, down = 1 -> 2, 1, 0, 2, 1, 0, ...; expire[2] pulses every 3 cycles on entry to 0.
- Simultaneous events:
  - Load 7 on ch0 in the same cycle its count goes 1->0 -> count = 7, no expire.
  - emg_load with load_val = {9, 8, 7, 6} -> all channels load at once.
- Freeze and zero-load:
  - ch3 load 4; down toggled 1, 0, 0, 1 -> counts 4, 3, 3, 3, 2.
  - Load 0 with auto_reload = 1 -> stays 0, expire never asserted.
- With PHASE_TIMER_PRESCALE_EN and PRESCALE = 4: ch0 load 2, down = 1 -> count decrements once every 4 clk cycles; expire occurs 8 cycles after the first tick-aligned window.
